instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//   IF stage: owns the PC, issues word reads to the instruction memory/cache and
//   delivers instruction+PC pairs to instruction_decode_unit via the IF/ID register.
//   A small FIFO decouples memory latency from decode stalls. Branch/jump redirects
//   from EX flush buffered and in-flight fetches.
// PARAMETERS
//   RESET_PC    32'h0000_0000  PC loaded on reset
//   FIFO_DEPTH  2              fetched-instruction buffer entries (power of 2, >=2)
//   NOP_INSTR   32'h0000_0013  addi x0,x0,0; driven when no valid instruction
// PORTS
//   clk              in   1   clock, all state on rising edge
//   reset            in   1   synchronous, active-low; one clock, no other clock domain
//   stall            in   1   hazard unit: hold IF/ID outputs, do not pop FIFO
//   branch_taken     in   1   EX redirect strobe (1 cycle)
//   branch_target    in   32  redirect PC, low 2 bits ignored (forced 0)
//   imem_read        out  1   fetch request
//   imem_address     out  32  word-aligned fetch address
//   imem_busy_wait   in   1   memory not ready; data valid at edge where low while imem_read
//   imem_readdata    in   32  fetched word
//   instruction      out  32  to decode; NOP_INSTR when instr_valid=0
//   pc_out           out  32  PC of instruction
//   pc_plus4         out  32  pc_out+4 (mod 2^32) for jal/jalr link
//   instr_valid      out  1   instruction/pc_out meaningful
// BEHAVIOUR
//   Reset (reset=0 at edge): fetch_pc=RESET_PC, FIFO empty, state=FETCH, imem_read=0,
//     imem_address=RESET_PC, instruction=NOP_INSTR, pc_out=0, pc_plus4=4, instr_valid=0.
//   FSM states: FETCH, WAIT, DISCARD.
//   FETCH: if FIFO not full, imem_read=1, imem_address=fetch_pc, go WAIT; else idle.
//   WAIT: imem_read=1, address held stable. Edge with imem_busy_wait=0: push
//     {fetch_pc, imem_readdata}, fetch_pc+=4 (wraps 32'hFFFF_FFFC->0), go FETCH.
//   DISCARD: entered on redirect while WAIT; imem_read stays 1 on the old address
//     until busy_wait=0 (memory transaction never abandoned); data dropped, go FETCH.
//   Redirect (branch_taken=1 at edge): fetch_pc=branch_target&~3, FIFO flushed,
//     instr_valid=0 next cycle; WAIT->DISCARD, FETCH stays FETCH. Redirect wins over
//     a same-edge push (pushed word dropped) and over stall. Redirect in DISCARD only
//     updates fetch_pc.
//   IF/ID output reg: when stall=0 and no redirect, load FIFO head and pop
//     (instr_valid=1), or load NOP_INSTR/instr_valid=0 if empty. stall=1 holds all
//     outputs and FIFO head; fetching continues until FIFO full.
//   Push and pop in same edge allowed when full (net occupancy unchanged); push into
//     empty FIFO is visible at outputs no earlier than next edge (min latency
//     request edge -> instr_valid: 2 cycles with zero-wait memory).
//   Mid-operation reset overrides everything, including DISCARD; response after
//     reset is ignored.
//   Zero-wait memory, no stalls/redirects: one instruction per cycle sustained.
// TESTING
//   Reset, zero-wait mem returning addr^32'hA5A5_0000: instr_valid rises on cycle 3,
//     pc_out 0,4,8,... each cycle, instruction matches, pc_plus4=pc_out+4.
//   busy_wait high 3 cycles per fetch: imem_address held stable across wait,
//     instr_valid pulses once per 4 cycles, no duplicate or skipped PC.
//   stall=1 for 5 cycles at pc_out=0x10: outputs frozen at 0x10, imem_read drops
//     once FIFO holds 2; release -> 0x14, 0x18 delivered back-to-back.
//   branch_taken with target 0x103 while WAIT on 0x20 with busy_wait high: old
//     response dropped, next fetch address 0x100, no instruction from 0x20..0x2C appears.
//   Redirect and busy_wait=0 on same edge: word dropped, next pc_out=target.
//   reset=0 asserted in WAIT/DISCARD: next cycle imem_read=0, instr_valid=0,
//     fetch resumes at RESET_PC; PC wrap at 0xFFFF_FFFC -> next 0x0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, runs one outstanding word read at a time,
// buffers returned words in a small FIFO and presents them to decode through the IF/ID register.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic        imem_busy_wait,
  input  logic [31:0] imem_readdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        instr_valid
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  state_e           state_r;
  state_e           state_s;
  logic [31:0]      fifo_pc_r   [FIFO_DEPTH];
  logic [31:0]      fifo_data_r [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_after_s;
  logic [31:0]      fetch_pc_r;
  logic [31:0]      fetch_pc_s;
  logic [31:0]      redirect_pc_s;
  logic             push_s;
  logic             pop_s;
  logic             issue_s;
  logic             empty_s;

  // State register for the fetch FSM
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: a completing read may immediately launch the next one when room remains
  always_comb begin
    state_s = ST_FETCH;
    case (state_r)
      ST_FETCH: begin
        if (issue_s) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_WAIT: begin
        if (imem_busy_wait) begin
          state_s = branch_taken ? ST_DISCARD : ST_WAIT;
        end else begin
          state_s = issue_s ? ST_WAIT : ST_FETCH;
        end
      end
      ST_DISCARD: begin
        if (imem_busy_wait) begin
          state_s = ST_DISCARD;
        end else begin
          state_s = ST_FETCH;
        end
      end
      default: state_s = ST_FETCH;
    endcase
  end

  // Control strobes; a redirect suppresses push, pop and issue on the same edge
  always_comb begin
    redirect_pc_s = branch_target & ~32'd3;
    empty_s       = (count_r == {CNT_W{1'b0}});
    pop_s         = !stall && !branch_taken && !empty_s;
    push_s        = (state_r == ST_WAIT) && !imem_busy_wait && !branch_taken;
    count_after_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    issue_s       = !branch_taken && ((state_r == ST_FETCH) || push_s) && (count_after_s < DEPTH_C);
    if (branch_taken) begin
      fetch_pc_s = redirect_pc_s;
    end else if (push_s) begin
      fetch_pc_s = fetch_pc_r + 32'd4;
    end else begin
      fetch_pc_s = fetch_pc_r;
    end
  end

  // Fetch PC and the memory request port; the address only moves when a new read is issued
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_r   <= RESET_PC;
      imem_read    <= 1'b0;
      imem_address <= RESET_PC;
    end else begin
      fetch_pc_r <= fetch_pc_s;
      imem_read  <= (state_s != ST_FETCH);
      if (issue_s) begin
        imem_address <= fetch_pc_s;
      end
    end
  end

  // Fetched-instruction FIFO, flushed by a redirect
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc_r[i]   <= 32'h0000_0000;
        fifo_data_r[i] <= 32'h0000_0000;
      end
    end else if (branch_taken) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        fifo_pc_r[wr_ptr_r]   <= fetch_pc_r;
        fifo_data_r[wr_ptr_r] <= imem_readdata;
        wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_after_s;
    end
  end

  // IF/ID register: pc_out/pc_plus4 keep their last values while no instruction is valid
  always_ff @(posedge clk) begin
    if (!reset) begin
      instruction <= NOP_INSTR;
      pc_out      <= 32'h0000_0000;
      pc_plus4    <= 32'h0000_0004;
      instr_valid <= 1'b0;
    end else if (branch_taken) begin
      instruction <= NOP_INSTR;
      instr_valid <= 1'b0;
    end else if (!stall) begin
      if (!empty_s) begin
        instruction <= fifo_data_r[rd_ptr_r];
        pc_out      <= fifo_pc_r[rd_ptr_r];
        pc_plus4    <= fifo_pc_r[rd_ptr_r] + 32'd4;
        instr_valid <= 1'b1;
      end else begin
        instruction <= NOP_INSTR;
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a latency-configurable memory model, a PC-stream
// scoreboard rebuilt on every reset/redirect, and directed plus randomised stimulus.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] XORK      = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_read;
  logic [31:0] imem_address;
  logic        imem_busy_wait;
  logic [31:0] imem_readdata;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        instr_valid;

  instruction_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .imem_read      (imem_read),
    .imem_address   (imem_address),
    .imem_busy_wait (imem_busy_wait),
    .imem_readdata  (imem_readdata),
    .instruction    (instruction),
    .pc_out         (pc_out),
    .pc_plus4       (pc_plus4),
    .instr_valid    (instr_valid)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          deliveries = 0;
  int          lat_mode = 0;     // 0..3 fixed wait cycles, 4 = random per request
  logic [31:0] exp_q[$];
  logic [31:0] exp_tail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected delivery order is simply consecutive words from the last redirect/reset PC
  task automatic sb_restart(input logic [31:0] base);
    exp_q.delete();
    exp_tail = base & ~32'd3;
  endtask

  task automatic sb_refill();
    while (exp_q.size() < 64) begin
      exp_q.push_back(exp_tail);
      exp_tail = exp_tail + 32'd4;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    sb_refill();
  endtask

  // Memory model: busy for mem_lat edges after a request starts, data = addr ^ XORK
  initial begin : memory
    int   mem_cnt;
    int   mem_lat;
    logic prev_read;
    logic prev_busy;
    mem_cnt = 0; mem_lat = 0; prev_read = 1'b0; prev_busy = 1'b0;
    imem_busy_wait = 1'b0;
    imem_readdata  = 32'h0;
    forever begin
      @(negedge clk);
      if (prev_read && prev_busy) begin
        mem_cnt++;
      end else begin
        mem_cnt = 0;
        mem_lat = (lat_mode == 4) ? int'($urandom_range(0, 3)) : lat_mode;
      end
      imem_busy_wait = imem_read && (mem_cnt < mem_lat);
      imem_readdata  = imem_address ^ XORK;
      prev_read      = imem_read;
      prev_busy      = imem_busy_wait;
    end
  end

  // Monitor: every edge, check reset/redirect/stall behaviour and pop the scoreboard per delivery
  initial begin : monitor
    logic [31:0] p_instr, p_pc, p_plus4, p_addr, got;
    logic        p_valid, p_read, s_reset, s_stall, s_bt, s_busy;
    p_instr = 32'h0; p_pc = 32'h0; p_plus4 = 32'h0; p_addr = 32'h0;
    p_valid = 1'b0; p_read = 1'b0;
    forever begin
      @(posedge clk);
      s_reset = reset; s_stall = stall; s_bt = branch_taken; s_busy = imem_busy_wait;
      #1;
      if (!s_reset) begin
        chk("reset_read", 32'(imem_read), 32'd0);
        chk("reset_valid", 32'(instr_valid), 32'd0);
        chk("reset_instr", instruction, NOP_INSTR);
        chk("reset_pc", pc_out, 32'd0);
        chk("reset_plus4", pc_plus4, 32'd4);
        chk("reset_addr", imem_address, RESET_PC);
      end else begin
        if (p_read && s_busy) begin
          chk("hold_read", 32'(imem_read), 32'd1);
          chk("hold_addr", imem_address, p_addr);
        end
        if (s_bt) begin
          chk("redirect_valid", 32'(instr_valid), 32'd0);
        end else if (s_stall) begin
          chk("stall_valid", 32'(instr_valid), 32'(p_valid));
          chk("stall_pc", pc_out, p_pc);
          chk("stall_instr", instruction, p_instr);
          chk("stall_plus4", pc_plus4, p_plus4);
        end else if (instr_valid) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_empty actual=%h expected=none", pc_out);
          end else begin
            got = exp_q.pop_front();
            chk("deliver_pc", pc_out, got);
            chk("deliver_instr", instruction, got ^ XORK);
            chk("deliver_plus4", pc_plus4, got + 32'd4);
            deliveries++;
          end
        end else begin
          chk("bubble_nop", instruction, NOP_INSTR);
        end
      end
      p_instr = instruction; p_pc = pc_out; p_plus4 = pc_plus4; p_valid = instr_valid;
      p_read = imem_read; p_addr = imem_address;
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    sb_restart(RESET_PC);
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] t);
    branch_taken  = 1'b1;
    branch_target = t;
    sb_restart(t);
    tick();
    branch_taken = 1'b0;
  endtask

  initial begin : stimulus
    int   first_k;
    int   run_cnt;
    int   vcnt;
    logic found;
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    lat_mode = 0;
    sb_restart(RESET_PC);
    tick(); tick(); tick();
    reset = 1'b1;

    // Zero-wait memory: first valid on the third edge, then one per cycle
    first_k = 0; run_cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (instr_valid && first_k == 0) first_k = k;
      if (k > 3 && instr_valid) run_cnt++;
    end
    chk("first_valid_cycle", 32'(first_k), 32'd3);
    chk("throughput", 32'(run_cnt), 32'd27);
    tick();

    // Stall at pc_out=0x10 for 5 cycles
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (instr_valid && pc_out == 32'h10) found = 1'b1;
    end
    chk("find_pc10", 32'(found), 32'd1);
    stall = 1'b1;
    repeat (5) tick();
    chk("stall_read_drop", 32'(imem_read), 32'd0);
    chk("stall_frozen_pc", pc_out, 32'h10);
    stall = 1'b0;
    tick();
    chk("release_pc0", pc_out, 32'h14);
    chk("release_v0", 32'(instr_valid), 32'd1);
    tick();
    chk("release_pc1", pc_out, 32'h18);
    chk("release_v1", 32'(instr_valid), 32'd1);

    // Three wait cycles per fetch: one delivery every four cycles
    lat_mode = 3;
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (instr_valid) found = 1'b1;
    end
    chk("busy_first_valid", 32'(found), 32'd1);
    vcnt = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (instr_valid) vcnt++;
    end
    chk("busy_rate", 32'(vcnt), 32'd10);

    // Redirect to 0x103 while waiting on 0x20
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 80 && !found; k++) begin
      tick();
      if (imem_read && imem_address == 32'h20 && imem_busy_wait) found = 1'b1;
    end
    chk("find_wait20", 32'(found), 32'd1);
    redirect(32'h103);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (imem_read && imem_address != 32'h20) found = 1'b1;
      else tick();
    end
    chk("redirect_addr", imem_address, 32'h100);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (instr_valid) found = 1'b1;
    end
    chk("redirect_first_pc", pc_out, 32'h100);

    // Redirect on the same edge as a completing read
    lat_mode = 2;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      tick();
      if (imem_read && !imem_busy_wait) found = 1'b1;
    end
    chk("find_complete", 32'(found), 32'd1);
    redirect(32'h200);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (instr_valid) found = 1'b1;
    end
    chk("sameedge_first_pc", pc_out, 32'h200);

    // Reset while WAIT, then while DISCARD
    lat_mode = 3;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (imem_read && imem_busy_wait) found = 1'b1;
    end
    chk("find_wait", 32'(found), 32'd1);
    reset = 1'b0; sb_restart(RESET_PC); tick(); reset = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick();
      if (imem_read) found = 1'b1;
    end
    chk("reset_resume_addr", imem_address, RESET_PC);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (imem_read && imem_busy_wait) found = 1'b1;
      else tick();
    end
    redirect(32'h300);
    reset = 1'b0; sb_restart(RESET_PC); tick(); reset = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (instr_valid) found = 1'b1;
    end
    chk("discard_reset_pc", pc_out, RESET_PC);

    // PC wrap past 0xFFFF_FFFC
    lat_mode = 0;
    redirect(32'hFFFF_FFF4);
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      tick();
      if (instr_valid && pc_out == 32'h0) found = 1'b1;
    end
    chk("wrap_to_zero", 32'(found), 32'd1);

    // Randomised stalls, latencies, redirects and occasional resets
    lat_mode = 4;
    for (int n = 0; n < 1500; n++) begin
      stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) < 3) begin
        branch_taken  = 1'b1;
        branch_target = $urandom;
        sb_restart(branch_target);
      end else begin
        branch_taken = 1'b0;
      end
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0;
        sb_restart(RESET_PC);
      end else begin
        reset = 1'b1;
      end
      tick();
    end
    branch_taken = 1'b0; stall = 1'b0; reset = 1'b1;
    repeat (5) tick();
    chk("liveness", 32'(deliveries >= 200), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
